// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: multi-approach traffic-signal phase controller.
//
// Serves NUM_DIR approaches one at a time through GREEN -> YELLOW -> ALLRED,
// skipping directions with no demand, and drops into a flashing-yellow night
// mode while flash_i is held. Every lamp output is decoded from registered
// state only, so no input reaches an output without passing a clock edge.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   flash_i       night-mode request (level)
//   req_i         per-direction demand, bit i = direction i (level)
//   light_o       lamp code per direction, slice [3i+2:3i] is direction i
//                 (red 001, green 010, yellow 100, off 000)
//   active_dir_o  direction currently or most recently served
//   phase_o       00 ALLRED, 01 GREEN, 10 YELLOW, 11 FLASH
module traffic_phase_ctrl #(
    parameter int unsigned NUM_DIR  = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned GREEN_T  = 8,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 2,
    parameter int unsigned FLASH_T  = 4,
    localparam int unsigned DIR_W   = $clog2(NUM_DIR)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flash_i,
    input  logic [NUM_DIR-1:0]     req_i,
    output logic [3*NUM_DIR-1:0]   light_o,
    output logic [DIR_W-1:0]       active_dir_o,
    output logic [1:0]             phase_o
);

    // The enum encoding is the phase_o code.
    typedef enum logic [1:0] {
        StAllRed = 2'b00,
        StGreen  = 2'b01,
        StYellow = 2'b10,
        StFlash  = 2'b11
    } state_e;

    // Timers count down from T-1 so a state lasts exactly T cycles.
    localparam logic [CNT_W-1:0] LdGreen  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] LdYellow = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] LdAllRed = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] LdFlash  = CNT_W'(FLASH_T - 1);
    localparam logic [DIR_W-1:0] DirLast  = DIR_W'(NUM_DIR - 1);

    localparam logic [2:0] LampOff    = 3'b000;
    localparam logic [2:0] LampRed    = 3'b001;
    localparam logic [2:0] LampGreen  = 3'b010;
    localparam logic [2:0] LampYellow = 3'b100;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [DIR_W-1:0] active_dir_q, active_dir_d;
    logic             flash_on_q, flash_on_d;

    // Round-robin search for the next requesting direction.
    logic [DIR_W:0]   shamt;
    logic [NUM_DIR-1:0] req_rot;
    int               off;
    int               sum;
    logic [DIR_W-1:0] next_dir;

    always_comb begin
        // Rotate req so bit 0 is the direction just after active_dir_q; the
        // doubled vector makes the wrap free. shamt reaches NUM_DIR at most.
        shamt   = {1'b0, active_dir_q} + (DIR_W + 1)'(1);
        req_rot = NUM_DIR'({req_i, req_i} >> shamt);
        // Lowest set bit wins; with no demand off stays 0, giving active+1.
        off = 0;
        for (int j = NUM_DIR - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                off = j;
            end
        end
        sum = int'(shamt) + off;
        if (sum >= int'(NUM_DIR)) begin
            sum = sum - int'(NUM_DIR);
        end
        next_dir = DIR_W'(sum);
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        active_dir_d = active_dir_q;
        flash_on_d   = flash_on_q;

        case (state_q)
            StAllRed: begin
                if (timer_q == '0) begin
                    if (flash_i) begin
                        state_d    = StFlash;
                        timer_d    = LdFlash;
                        flash_on_d = 1'b1;
                    end else begin
                        state_d      = StGreen;
                        timer_d      = LdGreen;
                        active_dir_d = next_dir;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            StGreen: begin
                // Night mode cuts green short but still passes through yellow.
                if (timer_q == '0 || flash_i) begin
                    state_d = StYellow;
                    timer_d = LdYellow;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            StYellow: begin
                if (timer_q == '0) begin
                    state_d = StAllRed;
                    timer_d = LdAllRed;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            StFlash: begin
                // Leaving night mode goes through a full all-red clearance.
                if (!flash_i) begin
                    state_d = StAllRed;
                    timer_d = LdAllRed;
                end else if (timer_q == '0) begin
                    flash_on_d = ~flash_on_q;
                    timer_d    = LdFlash;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StAllRed;
                timer_d = LdAllRed;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StAllRed;
            timer_q      <= LdAllRed;
            active_dir_q <= DirLast;
            flash_on_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            active_dir_q <= active_dir_d;
            flash_on_q   <= flash_on_d;
        end
    end

    // Moore lamp decode.
    always_comb begin
        light_o = '0;
        for (int i = 0; i < int'(NUM_DIR); i++) begin
            unique case (state_q)
                StAllRed: light_o[3*i +: 3] = LampRed;
                StGreen:  light_o[3*i +: 3] = (DIR_W'(i) == active_dir_q) ? LampGreen : LampRed;
                StYellow: light_o[3*i +: 3] = (DIR_W'(i) == active_dir_q) ? LampYellow : LampRed;
                StFlash:  light_o[3*i +: 3] = flash_on_q ? LampYellow : LampOff;
                default:  light_o[3*i +: 3] = LampRed;
            endcase
        end
    end

    assign active_dir_o = active_dir_q;
    assign phase_o      = state_q;

endmodule
